// File: rtl/stm_switch_sequencer.sv
// Hands the duty/phase datapath between the normal and STM operators.
// Optional STM_SWITCH_TIMED_SWITCH_EN registers the mode request against a switch time.
module stm_switch_sequencer #(
    parameter int IDX_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             OP_MODE,
    input  logic             USE_START_IDX,
    input  logic [IDX_W-1:0] START_IDX,
    input  logic             USE_FINISH_IDX,
    input  logic [IDX_W-1:0] FINISH_IDX,
    input  logic [IDX_W-1:0] STM_CYCLE,
    input  logic             STM_DONE,
    input  logic [IDX_W-1:0] STM_IDX,
    input  logic [63:0]      SYS_TIME,
    input  logic [63:0]      SWITCH_TIME,
    input  logic             SWITCH_TIME_VALID,
    output logic             STM_SEL,
    output logic [1:0]       STATE,
    output logic             SWITCH_PULSE,
    output logic [CNT_W-1:0] SWITCH_CNT,
    output logic             IDX_ERR
);

    localparam logic [1:0] S_NORMAL      = 2'd0;
    localparam logic [1:0] S_WAIT_START  = 2'd1;
    localparam logic [1:0] S_STM         = 2'd2;
    localparam logic [1:0] S_WAIT_FINISH = 2'd3;

    logic       op_eff;
    logic [1:0] state_next;
    logic       sel_next;
    logic       err_set;
    logic       err_clr;
    logic       start_ok;
    logic       finish_ok;
    logic       start_hit;
    logic       finish_hit;

`ifdef STM_SWITCH_TIMED_SWITCH_EN
    // Request only follows OP_MODE once the armed switch time is reached.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op_eff <= 1'b0;
        end else if (!SWITCH_TIME_VALID || (SYS_TIME >= SWITCH_TIME)) begin
            op_eff <= OP_MODE;
        end
    end
`else
    logic unused_time;
    assign unused_time = ^{SYS_TIME, SWITCH_TIME, SWITCH_TIME_VALID};
    assign op_eff = OP_MODE;
`endif

    assign start_ok   = START_IDX < STM_CYCLE;
    assign finish_ok  = FINISH_IDX < STM_CYCLE;
    assign start_hit  = STM_DONE && (STM_IDX == START_IDX);
    assign finish_hit = STM_DONE && (STM_IDX == FINISH_IDX);

    always_comb begin
        state_next = STATE;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        case (STATE)
            S_NORMAL: begin
                if (op_eff) begin
                    if (USE_START_IDX && start_ok) begin
                        state_next = S_WAIT_START;
                        err_clr    = 1'b1;
                    end else begin
                        state_next = S_STM;
                        err_set    = USE_START_IDX;
                    end
                end
            end
            S_WAIT_START: begin
                if (!op_eff) begin
                    state_next = S_NORMAL;
                end else if (start_hit) begin
                    state_next = S_STM;
                end
            end
            S_STM: begin
                if (!op_eff) begin
                    if (USE_FINISH_IDX && finish_ok) begin
                        state_next = S_WAIT_FINISH;
                        err_clr    = 1'b1;
                    end else begin
                        state_next = S_NORMAL;
                        err_set    = USE_FINISH_IDX;
                    end
                end
            end
            default: begin
                if (op_eff) begin
                    state_next = S_STM;
                end else if (finish_hit) begin
                    state_next = S_NORMAL;
                end
            end
        endcase
    end

    assign sel_next = (state_next == S_STM) || (state_next == S_WAIT_FINISH);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            STATE        <= S_NORMAL;
            STM_SEL      <= 1'b0;
            SWITCH_PULSE <= 1'b0;
            SWITCH_CNT   <= '0;
            IDX_ERR      <= 1'b0;
        end else begin
            STATE        <= state_next;
            STM_SEL      <= sel_next;
            SWITCH_PULSE <= sel_next != STM_SEL;
            if (sel_next != STM_SEL) begin
                SWITCH_CNT <= SWITCH_CNT + 1'b1;
            end
            if (err_set) begin
                IDX_ERR <= 1'b1;
            end else if (err_clr) begin
                IDX_ERR <= 1'b0;
            end
        end
    end

endmodule

// File: doc/stm_switch_sequencer.md
Name: stm_switch_sequencer

Overview:
Sequences handover of the transducer duty/phase datapath between the normal operator and the STM operator.
- Tracks the host-requested operating mode.
- Optionally holds the handover until the STM engine reaches a programmed start or finish index, so focus/gain sequences enter and leave at a defined point.
- Produces a registered select for the duty/phase mux ahead of the modulator and silencer, plus status and event outputs for GPIO/debug.

Parameters:
IDX_W, 16, width of STM index, start/finish index and STM_CYCLE
CNT_W, 16, width of SWITCH_CNT

Ports:
CLK  in  1  system (low-rate) clock
RST  in  1  asynchronous reset, active-high
OP_MODE  in  1  requested mode: 1 = STM, 0 = normal
USE_START_IDX  in  1  enter STM only at START_IDX
START_IDX  in  IDX_W  STM index at which STM output begins
USE_FINISH_IDX  in  1  leave STM only at FINISH_IDX
FINISH_IDX  in  IDX_W  STM index at which STM output ends
STM_CYCLE  in  IDX_W  number of STM points; valid indices 0..STM_CYCLE-1
STM_DONE  in  1  one-cycle pulse when STM_IDX advances
STM_IDX  in  IDX_W  current STM index, valid with STM_DONE
SYS_TIME  in  64  synchronized system time
SWITCH_TIME  in  64  scheduled switch time
SWITCH_TIME_VALID  in  1  scheduled switch armed
STM_SEL  out  1  1 = datapath driven by STM operator
STATE  out  2  0 NORMAL, 1 WAIT_START, 2 STM, 3 WAIT_FINISH
SWITCH_PULSE  out  1  one-cycle pulse on every STM_SEL change
SWITCH_CNT  out  CNT_W  count of STM_SEL changes
IDX_ERR  out  1  sticky flag: requested start/finish index out of range

Behaviour:
- Reset values: STATE=NORMAL, STM_SEL=0, SWITCH_PULSE=0, SWITCH_CNT=0, IDX_ERR=0. Reset mid-operation returns all of these immediately; no pending request survives reset.
- op_eff: effective mode request. Without the optional feature, op_eff = OP_MODE.
- STATE transitions; at most one transition per cycle:
  - NORMAL: if op_eff=1, go to WAIT_START when USE_START_IDX=1 and START_IDX<STM_CYCLE; otherwise go to STM.
  - WAIT_START: if op_eff=0, go to NORMAL (priority over an index match in the same cycle). Else if STM_DONE & STM_IDX==START_IDX, go to STM.
  - STM: if op_eff=0, go to WAIT_FINISH when USE_FINISH_IDX=1 and FINISH_IDX<STM_CYCLE; otherwise go to NORMAL.
  - WAIT_FINISH: if op_eff=1, go to STM (priority over an index match). Else if STM_DONE & STM_IDX==FINISH_IDX, go to NORMAL.
- Out-of-range index: USE_*_IDX=1 with index >= STM_CYCLE (including STM_CYCLE=0) means the transition is taken immediately. IDX_ERR is set on the same edge. IDX_ERR clears on the next in-range request; otherwise it holds until reset.
- STM_SEL is registered and equals (next STATE ∈ {STM, WAIT_FINISH}), so it changes on the same edge as STATE.
- Latency:
  - OP_MODE 0→1 with no index gating: STM_SEL=1 after 1 CLK edge.
  - Index-gated switch: STM_SEL=1 on the edge that samples the matching STM_DONE.
- SWITCH_PULSE is high for exactly the cycle after an STM_SEL change.
- SWITCH_CNT increments on the same edge and wraps 2^CNT_W-1 → 0.
- Index configuration inputs are sampled every cycle; changing them while in a WAIT_* state changes the match target immediately.
- WAIT_START does not drive STM_SEL. The normal datapath stays selected until the match.

Optional Feature:
Macro STM_SWITCH_TIMED_SWITCH_EN.
- Defined: op_eff is a register.
  - When SWITCH_TIME_VALID=0, op_eff <= OP_MODE every cycle (1 extra cycle of latency).
  - When SWITCH_TIME_VALID=1, op_eff <= OP_MODE only on cycles where SYS_TIME >= SWITCH_TIME (unsigned 64-bit compare); otherwise op_eff holds.
  - Reset value of op_eff is 0.
- Undefined: op_eff = OP_MODE combinationally. SYS_TIME, SWITCH_TIME and SWITCH_TIME_VALID are ignored and the ports remain present.

Test Plan:
- Reset, then OP_MODE=1, USE_START_IDX=0 → STM_SEL=1, STATE=2 one edge later; SWITCH_PULSE 1 cycle; SWITCH_CNT=1.
- STM_CYCLE=100, USE_START_IDX=1, START_IDX=37, OP_MODE=1, STM_DONE pulses with STM_IDX 30..40 → STATE=1 until the STM_IDX=37 pulse, then STM_SEL=1 on that edge. Drop OP_MODE in the same cycle as the match on a rerun → STATE=0, STM_SEL stays 0.
- In STM, USE_FINISH_IDX=1, FINISH_IDX=5, OP_MODE 1→0, then reassert OP_MODE before index 5 → STATE 2→3→2, STM_SEL stays 1 throughout, SWITCH_CNT unchanged.
- STM_CYCLE=10, START_IDX=12, USE_START_IDX=1, OP_MODE=1 → immediate STM, IDX_ERR=1. Next request with START_IDX=3 → IDX_ERR clears.
- Assert RST while STATE=3 → all outputs return to reset values asynchronously. 300 forced switches → SWITCH_CNT wraps correctly (CNT_W=8 build: 300 → 44).
- With STM_SWITCH_TIMED_SWITCH_EN: SWITCH_TIME=1000, VALID=1, OP_MODE=1 at SYS_TIME=900 → STM_SEL stays 0 until the first cycle with SYS_TIME>=1000, then 1 after 2 edges (op_eff register + state).
